// File: rtl/comp_pkg.sv
// Shared types and constants for the serial comparator.
package comp_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

endpackage

// File: rtl/celda_general_d_i.sv
// One bit of the serial comparison: p means "A<B over the bits seen so far".
// Purely combinational; the caller feeds bits LSB first and registers p_out.
module celda_general_d_i
  import comp_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic p_in,
  output logic p_out
);

  // A lower bit decides only when this bit ties.
  assign p_out = (~a_i & b_i) | (~(a_i ^ b_i) & p_in);

endmodule

// File: rtl/comp_serie_d_i.sv
// Bit-serial comparator, LSB first, done WIDTH+1 cycles after start; start ignored while busy.
// Define COMP_SIGNO_EN for two's-complement operands (MSB step swaps operand roles).
module comp_serie_d_i
  import comp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             menor,
  output logic             igual,
  output logic             mayor
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0]    cnt;
  logic             p, eq;
  logic             p_nxt;
  logic             cell_a, cell_b;
  logic             last_bit;
  logic             load, step, fin;

  assign last_bit = (cnt == LAST);

`ifdef COMP_SIGNO_EN
  // On the sign bit a set bit means the smaller value, so the roles of A and B swap.
  assign cell_a = last_bit ? sb[0] : sa[0];
  assign cell_b = last_bit ? sa[0] : sb[0];
`else
  assign cell_a = sa[0];
  assign cell_b = sb[0];
`endif

  celda_general_d_i u_celda (
    .a_i   (cell_a),
    .b_i   (cell_b),
    .p_in  (p),
    .p_out (p_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        step = 1'b1;
        if (last_bit) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        busy      = 1'b1;
        fin       = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
      p     <= 1'b0;
      eq    <= 1'b1;
      done  <= 1'b0;
      menor <= 1'b0;
      igual <= 1'b0;
      mayor <= 1'b0;
    end else begin
      done <= fin;
      if (load) begin
        sa  <= a;
        sb  <= b;
        cnt <= '0;
        p   <= 1'b0;
        eq  <= 1'b1;
      end else if (step) begin
        p   <= p_nxt;
        eq  <= eq & ~(sa[0] ^ sb[0]);
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        cnt <= cnt + 1'b1;
      end
      // Results hold until the next comparison finishes.
      if (fin) begin
        menor <= p & ~eq;
        igual <= eq;
        mayor <= ~p & ~eq;
      end
    end
  end

endmodule

// File: tb/tb_comp_serie_d_i.sv
// Directed bench for comp_serie_d_i at WIDTH=8 and WIDTH=1 against an arithmetic reference.
module tb_comp_serie_d_i;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy, done, menor, igual, mayor;

  logic       start1 = 1'b0;
  logic [0:0] a1 = 1'b0;
  logic [0:0] b1 = 1'b0;
  logic       busy1, done1, menor1, igual1, mayor1;

  int total = 0;
  int bad   = 0;

  comp_serie_d_i #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .menor(menor), .igual(igual), .mayor(mayor)
  );

  comp_serie_d_i #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .menor(menor1), .igual(igual1), .mayor(mayor1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {menor, igual, mayor} from plain integer comparison of w-bit operands.
  function automatic logic [2:0] ref_cmp(input logic [31:0] x, input logic [31:0] y, input int w);
    longint sx, sy, msk;
    msk = (longint'(1) << w) - 1;
    sx  = longint'(x) & msk;
    sy  = longint'(y) & msk;
`ifdef COMP_SIGNO_EN
    if (x[w-1]) sx = sx - (longint'(1) << w);
    if (y[w-1]) sy = sy - (longint'(1) << w);
`endif
    if (sx < sy) return 3'b100;
    else if (sx == sy) return 3'b010;
    else return 3'b001;
  endfunction

  // Reference: a comparison occupies WIDTH+1 cycles after acceptance, then pulses done.
  int         m_rem  = 0;
  logic       m_done = 1'b0;
  logic [2:0] m_res  = 3'b000;
  logic [2:0] m_pend = 3'b000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_res  <= 3'b000;
    end else begin
      m_done <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_done <= 1'b1;
          m_res  <= m_pend;
        end
      end else if (start) begin
        m_rem  <= 9;
        m_pend <= ref_cmp({24'b0, a}, {24'b0, b}, 8);
      end
    end
  end

  always @(negedge clk) begin
    chk("busy_vs_model", 32'(busy), 32'(m_rem > 0));
    chk("done_vs_model", 32'(done), 32'(m_done));
    if (m_rem == 0)
      chk("result_vs_model", 32'({menor, igual, mayor}), 32'(m_res));
  end

  task automatic go(input logic [7:0] x, input logic [7:0] y);
    start = 1'b1;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int nb);
    cyc = 0;
    nb  = 0;
    while (done !== 1'b1 && cyc < 40) begin
      nb += int'(busy);
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic go1(input logic x, input logic y, input logic [2:0] exp, input string name);
    int cyc;
    int nb;
    start1 = 1'b1;
    a1     = x;
    b1     = y;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 0;
    nb  = 0;
    while (done1 !== 1'b1 && cyc < 20) begin
      nb += int'(busy1);
      @(negedge clk);
      cyc++;
    end
    chk({name, "_latency"}, 32'(cyc), 32'd2);
    chk({name, "_busy"}, 32'(nb), 32'd2);
    chk({name, "_result"}, 32'({menor1, igual1, mayor1}), 32'(exp));
  endtask

  logic [7:0] va [6];
  logic [7:0] vb [6];
  logic [2:0] ve [6];

  initial begin
    int cyc;
    int nb;
    int ndone;

    va[0] = 8'd5;  vb[0] = 8'd9;  ve[0] = 3'b100;
    va[1] = 8'hA5; vb[1] = 8'hA5; ve[1] = 3'b010;
    va[3] = 8'h00; vb[3] = 8'h00; ve[3] = 3'b010;
    va[4] = 8'h01; vb[4] = 8'h00; ve[4] = 3'b001;
`ifdef COMP_SIGNO_EN
    va[2] = 8'hFF; vb[2] = 8'h00; ve[2] = 3'b100;
    va[5] = 8'h7F; vb[5] = 8'h80; ve[5] = 3'b001;
`else
    va[2] = 8'hFF; vb[2] = 8'h00; ve[2] = 3'b001;
    va[5] = 8'h7F; vb[5] = 8'h80; ve[5] = 3'b100;
`endif

    repeat (2) @(negedge clk);
    chk("reset_outputs_w8", 32'({busy, done, menor, igual, mayor}), 32'd0);
    chk("reset_outputs_w1", 32'({busy1, done1, menor1, igual1, mayor1}), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Table of vectors, each started in the cycle done is seen (back-to-back).
    for (int i = 0; i < 6; i++) begin
      go(va[i], vb[i]);
      wait_done(cyc, nb);
      chk($sformatf("vec%0d_latency", i), 32'(cyc), 32'd9);
      chk($sformatf("vec%0d_busy_cycles", i), 32'(nb), 32'd9);
      chk($sformatf("vec%0d_result", i), 32'({menor, igual, mayor}), 32'(ve[i]));
    end

    // Restart attempt while busy is ignored; then a back-to-back start in the done cycle.
    go(8'd3, 8'd4);
    repeat (2) @(negedge clk);
    go(8'd9, 8'd1);
    wait_done(cyc, nb);
    chk("ignore_restart_latency", 32'(cyc), 32'd6);
    chk("ignore_restart_result", 32'({menor, igual, mayor}), 32'(3'b100));
    go(8'h80, 8'h7F);
    wait_done(cyc, nb);
    chk("b2b_latency", 32'(cyc), 32'd9);
`ifdef COMP_SIGNO_EN
    chk("b2b_result", 32'({menor, igual, mayor}), 32'(3'b100));
`else
    chk("b2b_result", 32'({menor, igual, mayor}), 32'(3'b001));
`endif

    // Reset in the fourth busy cycle aborts the comparison silently.
    go(8'h10, 8'h20);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("midop_reset_outputs", 32'({busy, done, menor, igual, mayor}), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      ndone += int'(done);
    end
    chk("no_done_after_abort", 32'(ndone), 32'd0);
    go(8'h20, 8'h40);
    wait_done(cyc, nb);
    chk("post_reset_latency", 32'(cyc), 32'd9);
    chk("post_reset_result", 32'({menor, igual, mayor}), 32'(3'b100));

    // Single-bit instance.
    @(negedge clk);
    go1(1'b0, 1'b1, 3'b100, "w1_0_1");
    go1(1'b1, 1'b1, 3'b010, "w1_1_1");
`ifdef COMP_SIGNO_EN
    go1(1'b1, 1'b0, 3'b100, "w1_1_0");
`else
    go1(1'b1, 1'b0, 3'b001, "w1_1_0");
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
    $fatal(1);
  end

endmodule

// File: doc/comp_serie_d_i.md
COMP_SERIE_D_I -- requirements
Module: comp_serie_d_i

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits, legal range 1..32.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin a comparison; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  operand A; sampled in the same cycle that start is accepted.
REQ-006 SHALL have port b  input  WIDTH  operand B; sampled in the same cycle that start is accepted.
REQ-007 SHALL have port busy  output  1  high while a comparison is in progress (SHIFT or FIN).
REQ-008 SHALL have port done  output  1  one-cycle pulse marking valid results.
REQ-009 SHALL have port menor  output  1  A<B result.
REQ-010 SHALL have port igual  output  1  A==B result.
REQ-011 SHALL have port mayor  output  1  A>B result.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, SHIFT and FIN.
REQ-013 SHALL, in IDLE with start=1, load a and b into shift registers, clear the bit counter, set p=0 and eq=1, and go to SHIFT; start=0 stays in IDLE.
REQ-014 SHALL, in SHIFT, process one bit per cycle from right to left (LSB first): p <= (~a_i & b_i) | (~(a_i ^ b_i) & p), eq <= eq & ~(a_i ^ b_i), then shift both registers right.
REQ-015 SHALL have the bit-0 step reduce to p = ~a_0 & b_0, because p starts at 0.
REQ-016 SHALL leave SHIFT for FIN after processing bit WIDTH-1; the counter width SHALL be $clog2(WIDTH+1).
REQ-017 SHALL, in FIN, register menor=p & ~eq, igual=eq and mayor=~p & ~eq, assert done for exactly one cycle, and return to IDLE.
REQ-018 SHALL assert done exactly WIDTH+1 cycles after the edge that accepted start.
REQ-019 SHALL keep menor, igual and mayor stable from done until the next accepted start; exactly one of the three SHALL be high after the first completed comparison.
REQ-020 SHALL ignore start while busy=1, with no restart and no queueing.
REQ-021 SHALL accept start in the IDLE cycle immediately after FIN, allowing back-to-back operation.
REQ-022 SHALL work for WIDTH=1: a single SHIFT cycle, then FIN.

Reset
REQ-023 SHALL, on rst_n=0 at any time including mid-operation, force IDLE, busy=0, done=0, menor=0, igual=0, mayor=0, clear shift registers and counter, and set p=0 and eq=1.
REQ-024 SHALL never assert done for an aborted comparison after reset is released.

Configuration
REQ-025 SHALL support macro COMP_SIGNO_EN; when defined, operands are two's complement and the MSB step (bit WIDTH-1) uses p <= (a_i & ~b_i) | (~(a_i ^ b_i) & p).
REQ-026 SHALL, without COMP_SIGNO_EN, perform unsigned comparison, using the REQ-014 equation for every bit.
REQ-027 SHALL keep latency and handshake identical in both configurations.

Structure
REQ-028 SHALL place the FSM state typedef (IDLE/SHIFT/FIN) and the default-width constant in shared package comp_pkg.
REQ-029 SHALL implement the per-bit recurrence as combinational sub-module celda_general_d_i (inputs a_i, b_i, p_in; output p_out), instantiated once and reused every cycle.

Verification
REQ-030 SHALL cover: WIDTH=8, A=5, B=9, start pulse -> busy for 9 cycles, done at cycle 9, menor=1, igual=0, mayor=0.
REQ-031 SHALL cover: WIDTH=8, A=B=0xA5 -> igual=1, menor=0, mayor=0 at done.
REQ-032 SHALL cover: WIDTH=8, A=0xFF, B=0x00 -> mayor=1 without COMP_SIGNO_EN; menor=1 (-1<0) with COMP_SIGNO_EN.
REQ-033 SHALL cover: start A=3, B=4; new start with A=9, B=1 at cycle 3 -> second start ignored, done at cycle 9 with menor=1, then a back-to-back start is accepted in the next IDLE cycle.
REQ-034 SHALL cover: rst_n low at cycle 4 of a comparison -> all outputs 0 immediately, no done pulse after release, and the next comparison is correct.
REQ-035 SHALL cover: WIDTH=1, A=0, B=1 -> done 2 cycles after start, menor=1.
